// File: rtl/load_store_controller.sv
// Data-memory access sequencer: checks and issues one load or store at a time over a
// valid/ready request channel, stalls the pipeline meanwhile, and aligns/extends loads.

module load_store_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  store,
  input  logic [2:0]            func_3,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [DATA_WIDTH-1:0] mem_req_address,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_data_valid,
  output logic                  access_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    RESPONSE = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic [2:0]    func_q;
  logic [1:0]    offset_q;
  logic          deliver;

  logic          start;
  logic          legal;
  logic          aligned;
  logic          go;
  logic          timed_out;
  logic          capture;
  logic [3:0]    wmask_new;
  logic [31:0]   wdata_new;
  logic [31:0]   shifted;
  logic [31:0]   extended;

  // Decode the strobe in IDLE; a store always wins when both strobes are high.
  always_comb begin
    start     = load | store;
    legal     = store ? (func_3 <= 3'd2) : ((func_3 != 3'd3) && (func_3 <= 3'd5));
    aligned   = 1'b1;
    wmask_new = 4'b0000;
    wdata_new = 32'h0;
    if (func_3[1:0] == 2'd1) begin
      aligned = ~address[0];
    end else if (func_3[1:0] == 2'd2) begin
      aligned = (address[1:0] == 2'b00);
    end
    if (store) begin
      case (func_3[1:0])
        2'd0: begin
          wmask_new = 4'b0001 << address[1:0];
          wdata_new = {4{store_data[7:0]}};
        end
        2'd1: begin
          wmask_new = 4'b0011 << address[1:0];
          wdata_new = {2{store_data[15:0]}};
        end
        default: begin
          wmask_new = 4'b1111;
          wdata_new = store_data;
        end
      endcase
    end
  end

  assign go = start & legal & aligned;

  // Shift the addressed lane down to bit 0, then extend according to the captured size.
  always_comb begin
    shifted = mem_resp_rdata >> {offset_q, 3'b000};
    case (func_q)
      3'd0:    extended = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    extended = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    extended = {24'h0, shifted[7:0]};
      3'd5:    extended = {16'h0, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The timeout cycle drops valid, so a late ready can never complete an abandoned request.
  always_comb begin
    state_next      = state;
    mem_req_valid   = 1'b0;
    stall           = 1'b0;
    access_error    = 1'b0;
    load_data_valid = 1'b0;
    capture         = 1'b0;
    timed_out       = (timer == TW'(TIMEOUT_CYCLES));
    case (state)
      IDLE: begin
        if (go) begin
          stall      = 1'b1;
          state_next = REQUEST;
        end else if (start) begin
          access_error = 1'b1;
        end
      end
      REQUEST: begin
        stall = 1'b1;
        if (timed_out) begin
          access_error = 1'b1;
          state_next   = DONE;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            state_next = mem_req_write ? DONE : RESPONSE;
          end
        end
      end
      RESPONSE: begin
        stall = 1'b1;
        if (timed_out) begin
          access_error = 1'b1;
          state_next   = DONE;
        end else if (mem_resp_valid) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        load_data_valid = deliver;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once in IDLE and held for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer           <= '0;
      func_q          <= 3'd0;
      offset_q        <= 2'd0;
      deliver         <= 1'b0;
      mem_req_write   <= 1'b0;
      mem_req_address <= '0;
      mem_req_wdata   <= '0;
      mem_req_wmask   <= 4'b0000;
      load_data       <= '0;
    end else begin
      timer   <= ((state_next == state) && ((state == REQUEST) || (state == RESPONSE))) ?
                 timer + 1'b1 : '0;
      deliver <= capture;
      if ((state == IDLE) && go) begin
        func_q          <= func_3;
        offset_q        <= address[1:0];
        mem_req_write   <= store;
        mem_req_address <= {address[31:2], 2'b00};
        mem_req_wdata   <= wdata_new;
        mem_req_wmask   <= wmask_new;
      end
      if (capture) begin
        load_data <= extended;
      end
    end
  end

endmodule
